ddr_host_seq: RTL and testbench
===============================

Name: ddr_host_seq

Overview:
Synchronous host-side command sequencer between the board switch/LED interface and the ddr_sdram controller. It replaces free-running switch-edge logic with a clocked datapath:
- debounces and edge-detects the six push switches;
- latches write data from the DIP switches;
- issues single-cycle WRITE/READ strobes under the controller's BUSY handshake;
- captures read data on the controller's EXT_DQS strobe and drives the LEDs.

Parameters:
DEBOUNCE_CYCLES, 1000000, stable-input cycles required before a switch level is accepted (10 ms at 100 MHz)
TIMEOUT_CYCLES, 4095, max cycles waiting for BUSY rise, BUSY fall or EXT_DQS before abort
BURST_LENGTH, 2, column increment applied after each completed access

Ports:
SYS_CLK_100M  in   1   system clock; all logic on its rising edge
RST_N         in   1   reset, asynchronous, active-low
DPSwitch      in   8   raw DIP switch data byte
Switch        in   6   raw push switches: 0 load upper, 1 load lower, 2 write, 3 read, 4 show upper, 5 show lower
BUSY          in   1   controller busy
EXT_DQS       in   1   controller read-data strobe
RDATA         in   16  controller read data bus (valid at EXT_DQS rise)
WRITE         out  1   one-cycle write request
READ          out  1   one-cycle read request
WDATA         out  16  write data to controller
DATA_OE       out  1   1 = top level drives WDATA onto controller DATA_IN
BA_IN         out  2   bank address, constant 0
ADDR_ROW_IN   out  13  row address, constant 0
ADDR_COL_IN   out  10  column address, auto-incrementing
WRITE_LENGTH  out  4   constant 4'd1
ERR           out  1   sticky timeout flag
LED           out  8   display byte

Behaviour:
- Reset (RST_N low, async) sets every output and register to 0, with two exceptions:
  - WRITE_LENGTH = 1;
  - FSM state = IDLE.
  This also clears WDATA, read_data, ADDR_COL_IN, ERR, LED, debounce counters and the edge-detect history.
- Switch conditioning, per switch:
  - 2-FF synchronizer, then a counter.
  - A level change is accepted only after DEBOUNCE_CYCLES consecutive cycles at the new level.
  - A press is a one-cycle pulse on the accepted 0->1 transition. Releases produce no pulse.
- Data load:
  - Press0 loads WDATA[15:8] from DPSwitch.
  - Press1 loads WDATA[7:0] from DPSwitch.
  - Both presses in the same cycle load both halves.
  - Loads are accepted in any FSM state; WDATA is stable while DATA_OE=1 because loads are deferred until return to IDLE.
- FSM states: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
  - IDLE:
    - Press2 with BUSY=0 -> WR_REQ.
    - Else Press3 with BUSY=0 -> RD_REQ. Write has priority when both occur in the same cycle.
    - Presses arriving with BUSY=1, or in any non-IDLE state, are dropped (not queued).
  - WR_REQ: WRITE=1 for exactly one cycle, DATA_OE=1 -> WR_WAIT.
  - WR_WAIT:
    - DATA_OE held at 1.
    - Wait for BUSY=1, then for BUSY=0 -> DONE.
  - RD_REQ: READ=1 for exactly one cycle -> RD_WAIT.
  - RD_WAIT:
    - EXT_DQS passes through a 2-FF synchronizer.
    - The first synchronized rising edge captures RDATA into read_data (the capture register uses the delayed-sampled RDATA aligned to the synchronizer).
    - Then wait for BUSY=0 -> DONE.
  - DONE: ADDR_COL_IN <= ADDR_COL_IN + BURST_LENGTH, modulo 1024 (wraps 1022 -> 0 for BL=2) -> IDLE.
  - Timeout:
    - One counter, cleared on each state entry.
    - In WR_WAIT or RD_WAIT, reaching TIMEOUT_CYCLES sets ERR=1 and returns to IDLE.
    - On timeout: no address increment; read_data is unchanged unless already captured.
  - ERR clears only on reset.
- LED:
  - Press4 sets LED <= read_data[15:8].
  - Press5 sets LED <= read_data[7:0].
  - If both occur in the same cycle, Press5 wins.
  - LED does not track later read_data changes until the next press.
- Latency: a debounced press accepted in IDLE produces the WRITE/READ strobe exactly 1 cycle after the press pulse.
- Reset mid-operation: all strobes deassert immediately, DATA_OE=0, FSM = IDLE.

Decomposition:
- Shared package ddr_host_pkg holds:
  - FSM state enum;
  - switch index constants (SW_LOAD_HI=0 … SW_SHOW_LO=5);
  - constant widths (ROW 13, COL 10, BA 2, DATA 16).
- One sub-module, sw_debounce: synchronizer + counter + rise pulse, parameterised by DEBOUNCE_CYCLES. Instantiate it 6 times.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=32):
- Bounce: Switch[0] toggles 0/1 every 2 cycles for 20 cycles, then stays high, with DPSwitch=8'hA5 -> exactly one load; WDATA[15:8]=8'hA5 after ~6 stable cycles.
- Write handshake: WDATA=16'h1234, press Switch[2], BUSY model rises 3 cycles after WRITE and falls 10 cycles later.
  - Required: one-cycle WRITE; DATA_OE high from WR_REQ through WR_WAIT; ADDR_COL_IN 0->2 at DONE.
- Read capture: press Switch[3], model pulses EXT_DQS with RDATA=16'hBEEF, then drops BUSY.
  - Then press Switch[4] -> LED=8'hBE; press Switch[5] -> LED=8'hEF; ADDR_COL_IN advances by 2.
- Busy drop: hold BUSY=1 and press Switch[2] and Switch[3] -> no WRITE/READ strobe; FSM stays IDLE.
- Simultaneous press and wrap: preset ADDR_COL_IN to 1022 via 511 writes, or by forcing; press Switch[2] and Switch[3] in the same cycle.
  - Required: only WRITE issued; ADDR_COL_IN wraps to 0.
- Timeout and reset: press Switch[3] with BUSY never rising and no EXT_DQS -> ERR=1 after 32 cycles, back in IDLE, ADDR_COL_IN unchanged.
  - Then RST_N low mid-WR_WAIT -> WRITE=0, DATA_OE=0, ERR=0 immediately.

Source files
------------

// File: rtl/ddr_host_pkg.sv
// Shared widths, switch indices and sequencer state encodings for the DDR host
// sequencer and its board/controller interface.
package ddr_host_pkg;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 10;
  localparam int BA_W   = 2;
  localparam int DATA_W = 16;

  localparam int SW_LOAD_HI = 0;
  localparam int SW_LOAD_LO = 1;
  localparam int SW_WRITE   = 2;
  localparam int SW_READ    = 3;
  localparam int SW_SHOW_HI = 4;
  localparam int SW_SHOW_LO = 5;
  localparam int SW_N       = 6;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_REQ  = 3'd1;
  localparam state_t ST_WR_WAIT = 3'd2;
  localparam state_t ST_RD_REQ  = 3'd3;
  localparam state_t ST_RD_WAIT = 3'd4;
  localparam state_t ST_DONE    = 3'd5;
endpackage

// File: rtl/ddr_host_seq_if.sv
// Command/data handshake between the host sequencer (master) and the
// ddr_sdram controller (slave).
interface ddr_host_seq_if;
  import ddr_host_pkg::*;

  logic              WRITE;
  logic              READ;
  logic [DATA_W-1:0] WDATA;
  logic              DATA_OE;
  logic [BA_W-1:0]   BA_IN;
  logic [ROW_W-1:0]  ADDR_ROW_IN;
  logic [COL_W-1:0]  ADDR_COL_IN;
  logic [3:0]        WRITE_LENGTH;
  logic              BUSY;
  logic              EXT_DQS;
  logic [DATA_W-1:0] RDATA;

  modport master (
    output WRITE, READ, WDATA, DATA_OE, BA_IN, ADDR_ROW_IN, ADDR_COL_IN, WRITE_LENGTH,
    input  BUSY, EXT_DQS, RDATA
  );

  modport slave (
    input  WRITE, READ, WDATA, DATA_OE, BA_IN, ADDR_ROW_IN, ADDR_COL_IN, WRITE_LENGTH,
    output BUSY, EXT_DQS, RDATA
  );
endinterface

// File: rtl/ddr_host_seq_sw_debounce.sv
// Push-switch conditioner: 2-FF synchronizer, down-counting stability timer and
// a one-cycle pulse on each accepted press (releases are silent).
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1, sync2, level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      // Any cycle back at the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= CW'(DEBOUNCE_CYCLES - 1);
      end else if (cnt == '0) begin
        level <= sync2;
        press <= sync2;
        cnt   <= CW'(DEBOUNCE_CYCLES - 1);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/ddr_host_seq.sv
// Host-side command sequencer: conditions the board switches, latches write data,
// issues WRITE/READ strobes under the BUSY handshake and shows read data on the LEDs.
module ddr_host_seq
  import ddr_host_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 4095,
  parameter int unsigned BURST_LENGTH    = 2
) (
  input  logic        SYS_CLK_100M,
  input  logic        RST_N,
  input  logic [7:0]  DPSwitch,
  input  logic [5:0]  Switch,
  output logic        ERR,
  output logic [7:0]  LED,
  ddr_host_seq_if.master ctl
);
  // state      | meaning
  // ST_IDLE    | waiting for a write/read press with BUSY low
  // ST_WR_REQ  | one-cycle WRITE strobe, WDATA driven
  // ST_WR_WAIT | WDATA driven, wait BUSY rise then fall
  // ST_RD_REQ  | one-cycle READ strobe
  // ST_RD_WAIT | capture RDATA on first DQS rise, then wait BUSY low
  // ST_DONE    | advance column address by the burst length
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW_N-1:0]   press;
  state_t            state, state_nxt;
  logic [TW-1:0]     tmr;
  logic              timeout, seen_busy, captured, data_oe, dqs_rise;
  logic              dqs_s1, dqs_s2, dqs_s3;
  logic [DATA_W-1:0] rdata_d1, rdata_d2, read_data, wdata;
  logic [7:0]        pend_hi_val, pend_lo_val;
  logic              pend_hi, pend_lo;
  logic [COL_W-1:0]  col;

  for (genvar i = 0; i < SW_N; i++) begin : g_sw
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (SYS_CLK_100M),
      .rst_n (RST_N),
      .raw   (Switch[i]),
      .press (press[i])
    );
  end

  assign data_oe          = (state == ST_WR_REQ) || (state == ST_WR_WAIT);
  assign dqs_rise         = dqs_s2 & ~dqs_s3;
  assign ctl.WRITE        = (state == ST_WR_REQ);
  assign ctl.READ         = (state == ST_RD_REQ);
  assign ctl.DATA_OE      = data_oe;
  assign ctl.WDATA        = wdata;
  assign ctl.BA_IN        = '0;
  assign ctl.ADDR_ROW_IN  = '0;
  assign ctl.ADDR_COL_IN  = col;
  assign ctl.WRITE_LENGTH = 4'd1;

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press[SW_WRITE] && !ctl.BUSY)     state_nxt = ST_WR_REQ;
        else if (press[SW_READ] && !ctl.BUSY) state_nxt = ST_RD_REQ;
      end
      ST_WR_REQ: state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (seen_busy && !ctl.BUSY) state_nxt = ST_DONE;
        else if (tmr == '0) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      ST_RD_REQ: state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (captured && !ctl.BUSY) state_nxt = ST_DONE;
        else if (tmr == '0) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      seen_busy <= 1'b0;
      captured  <= 1'b0;
      read_data <= '0;
      col       <= '0;
      ERR       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) tmr <= TW'(TIMEOUT_CYCLES - 1);
      else if (tmr != '0)     tmr <= tmr - 1'b1;
      if (state == ST_WR_REQ)                       seen_busy <= 1'b0;
      else if (state == ST_WR_WAIT && ctl.BUSY)     seen_busy <= 1'b1;
      if (state == ST_RD_REQ) captured <= 1'b0;
      else if (state == ST_RD_WAIT && dqs_rise && !captured) begin
        captured  <= 1'b1;
        read_data <= rdata_d2;
      end
      if (timeout)           ERR <= 1'b1;
      if (state == ST_DONE)  col <= col + COL_W'(BURST_LENGTH);
    end
  end

  // RDATA is delayed to match the DQS synchronizer so the captured word is the one present at the strobe.
  always_ff @(posedge SYS_CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      dqs_s1      <= 1'b0;
      dqs_s2      <= 1'b0;
      dqs_s3      <= 1'b0;
      rdata_d1    <= '0;
      rdata_d2    <= '0;
      wdata       <= '0;
      pend_hi     <= 1'b0;
      pend_lo     <= 1'b0;
      pend_hi_val <= '0;
      pend_lo_val <= '0;
      LED         <= '0;
    end else begin
      dqs_s1   <= ctl.EXT_DQS;
      dqs_s2   <= dqs_s1;
      dqs_s3   <= dqs_s2;
      rdata_d1 <= ctl.RDATA;
      rdata_d2 <= rdata_d1;

      if (!data_oe) begin
        pend_hi <= 1'b0;
        pend_lo <= 1'b0;
        if (press[SW_LOAD_HI]) wdata[15:8] <= DPSwitch;
        else if (pend_hi)      wdata[15:8] <= pend_hi_val;
        if (press[SW_LOAD_LO]) wdata[7:0]  <= DPSwitch;
        else if (pend_lo)      wdata[7:0]  <= pend_lo_val;
      end else begin
        if (press[SW_LOAD_HI]) begin
          pend_hi     <= 1'b1;
          pend_hi_val <= DPSwitch;
        end
        if (press[SW_LOAD_LO]) begin
          pend_lo     <= 1'b1;
          pend_lo_val <= DPSwitch;
        end
      end

      if (press[SW_SHOW_LO])      LED <= read_data[7:0];
      else if (press[SW_SHOW_HI]) LED <= read_data[15:8];
    end
  end
endmodule

// File: tb/tb_ddr_host_seq.sv
// Randomized bench for ddr_host_seq with a transaction-level expectation model
// and a simple controller responder.
module tb_ddr_host_seq;
  import ddr_host_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  dp = '0;
  logic [5:0]  sw = '0;
  logic        err;
  logic [7:0]  led;
  logic        busy_m = 1'b0, hold_busy = 1'b0, dqs_m = 1'b0, respond = 1'b1;
  logic [15:0] rdata_m = '0, rd_val = '0;

  int checks = 0, errors = 0;
  int wr_cnt = 0, rd_cnt = 0, proto_err = 0, oe_len = 0, last_oe_len = 0;
  int exp_col = 0, exp_wr = 0, exp_rd_cnt = 0;
  logic [15:0] exp_wd = '0, exp_rd = '0;
  logic [7:0]  exp_led = '0, b;

  ddr_host_seq_if ifc();
  assign ifc.BUSY    = busy_m | hold_busy;
  assign ifc.EXT_DQS = dqs_m;
  assign ifc.RDATA   = rdata_m;

  ddr_host_seq #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(32), .BURST_LENGTH(2)) dut (
    .SYS_CLK_100M (clk),
    .RST_N        (rst_n),
    .DPSwitch     (dp),
    .Switch       (sw),
    .ERR          (err),
    .LED          (led),
    .ctl          (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe/handshake observer
  initial begin
    logic prev_wr, prev_oe;
    logic [15:0] prev_wd;
    prev_wr = 1'b0; prev_oe = 1'b0; prev_wd = '0;
    forever begin
      @(negedge clk);
      if (ifc.WRITE) wr_cnt++;
      if (ifc.READ)  rd_cnt++;
      if (ifc.WRITE && prev_wr) proto_err++;
      if (ifc.WRITE && !ifc.DATA_OE) proto_err++;
      if (ifc.DATA_OE && prev_oe && ifc.WDATA !== prev_wd) proto_err++;
      if (ifc.DATA_OE) oe_len++;
      else if (oe_len > 0) begin
        last_oe_len = oe_len;
        oe_len = 0;
      end
      prev_wr = ifc.WRITE; prev_oe = ifc.DATA_OE; prev_wd = ifc.WDATA;
    end
  end

  // Controller responder: BUSY 3 cycles after WRITE for 10 cycles; reads pulse DQS with rd_val
  initial begin
    forever begin
      @(negedge clk);
      if (respond && ifc.WRITE) begin
        repeat (3) @(negedge clk);
        busy_m = 1'b1;
        repeat (10) @(negedge clk);
        busy_m = 1'b0;
      end else if (respond && ifc.READ) begin
        repeat (3) @(negedge clk);
        busy_m = 1'b1;
        repeat (3) @(negedge clk);
        rdata_m = rd_val;
        dqs_m = 1'b1;
        repeat (2) @(negedge clk);
        dqs_m = 1'b0;
        rdata_m = 16'($urandom);
        repeat (3) @(negedge clk);
        busy_m = 1'b0;
      end
    end
  end

  task automatic op(input logic [5:0] m, input int extra);
    sw = m;
    repeat (8) @(negedge clk);
    sw = '0;
    repeat (8 + extra) @(negedge clk);
  endtask

  task automatic do_write();
    op(6'd4, 20);
    exp_wr++;
    exp_col = (exp_col + 2) % 1024;
  endtask

  initial begin
    int k;
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_write", 32'(ifc.WRITE), 0);
    chk("rst_read", 32'(ifc.READ), 0);
    chk("rst_oe", 32'(ifc.DATA_OE), 0);
    chk("rst_wlen", 32'(ifc.WRITE_LENGTH), 1);
    chk("rst_col", 32'(ifc.ADDR_COL_IN), 0);
    chk("rst_err_led", 32'({err, led, ifc.WDATA}), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // bounce on Switch[0]
    dp = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      sw[0] = ~sw[0];
      repeat (2) @(negedge clk);
    end
    chk("bounce_quiet", 32'(ifc.WDATA), 0);
    sw[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("bounce_load", 32'(ifc.WDATA), 32'h0000A500);
    dp = 8'h3C;
    repeat (4) @(negedge clk);
    chk("bounce_once", 32'(ifc.WDATA), 32'h0000A500);
    sw = '0;
    repeat (8) @(negedge clk);

    dp = 8'h12; op(6'd1, 4);
    dp = 8'h34; op(6'd2, 4);
    exp_wd = 16'h1234;
    chk("wdata_1234", 32'(ifc.WDATA), 32'(exp_wd));

    do_write();
    chk("wr_strobes", 32'(wr_cnt), 32'(exp_wr));
    chk("wr_col", 32'(ifc.ADDR_COL_IN), 32'(exp_col));
    chk("wr_oe_len", 32'(last_oe_len), 14);

    rd_val = 16'hBEEF;
    op(6'd8, 20);
    exp_rd_cnt++; exp_rd = rd_val; exp_col = (exp_col + 2) % 1024;
    chk("rd_strobes", 32'(rd_cnt), 32'(exp_rd_cnt));
    chk("rd_col", 32'(ifc.ADDR_COL_IN), 32'(exp_col));
    op(6'd16, 4);
    chk("led_hi", 32'(led), 32'h000000BE);
    op(6'd32, 4);
    chk("led_lo", 32'(led), 32'h000000EF);
    exp_led = 8'hEF;

    // presses while BUSY is held are dropped
    hold_busy = 1'b1;
    op(6'd12, 20);
    hold_busy = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_drop_wr", 32'(wr_cnt), 32'(exp_wr));
    chk("busy_drop_rd", 32'(rd_cnt), 32'(exp_rd_cnt));
    chk("busy_drop_col", 32'(ifc.ADDR_COL_IN), 32'(exp_col));

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: begin
          b = 8'($urandom); dp = b; op(6'd1, 4); exp_wd[15:8] = b;
          chk("rnd_ld_hi", 32'(ifc.WDATA), 32'(exp_wd));
        end
        1: begin
          b = 8'($urandom); dp = b; op(6'd2, 4); exp_wd[7:0] = b;
          chk("rnd_ld_lo", 32'(ifc.WDATA), 32'(exp_wd));
        end
        2: begin
          do_write();
          chk("rnd_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
          chk("rnd_wr_col", 32'(ifc.ADDR_COL_IN), 32'(exp_col));
        end
        3: begin
          rd_val = 16'($urandom);
          op(6'd8, 20);
          exp_rd_cnt++; exp_rd = rd_val; exp_col = (exp_col + 2) % 1024;
          chk("rnd_rd_cnt", 32'(rd_cnt), 32'(exp_rd_cnt));
          chk("rnd_rd_col", 32'(ifc.ADDR_COL_IN), 32'(exp_col));
        end
        4: begin
          op(6'd16, 4); exp_led = exp_rd[15:8];
          chk("rnd_led_hi", 32'(led), 32'(exp_led));
        end
        default: begin
          op(6'd32, 4); exp_led = exp_rd[7:0];
          chk("rnd_led_lo", 32'(led), 32'(exp_led));
        end
      endcase
    end
    chk("rnd_err", 32'(err), 0);

    // walk the column to 1022, then a simultaneous write+read press must wrap it
    while (exp_col != 1022) do_write();
    chk("pre_wrap_col", 32'(ifc.ADDR_COL_IN), 1022);
    op(6'd12, 20);
    exp_wr++; exp_col = 0;
    chk("both_wr", 32'(wr_cnt), 32'(exp_wr));
    chk("both_rd", 32'(rd_cnt), 32'(exp_rd_cnt));
    chk("wrap_col", 32'(ifc.ADDR_COL_IN), 32'(exp_col));

    // read with a silent controller times out
    respond = 1'b0;
    sw = 6'd8;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ifc.READ) found = 1'b1;
    end
    chk("to_strobe", 32'(found), 1);
    exp_rd_cnt++;
    repeat (28) @(negedge clk);
    chk("to_err_early", 32'(err), 0);
    repeat (10) @(negedge clk);
    chk("to_err", 32'(err), 1);
    sw = '0;
    repeat (8) @(negedge clk);
    chk("to_col", 32'(ifc.ADDR_COL_IN), 32'(exp_col));
    chk("to_rd_cnt", 32'(rd_cnt), 32'(exp_rd_cnt));
    respond = 1'b1;
    do_write();
    chk("to_idle_wr", 32'(wr_cnt), 32'(exp_wr));
    chk("to_idle_col", 32'(ifc.ADDR_COL_IN), 32'(exp_col));
    chk("err_sticky", 32'(err), 1);
    chk("proto", 32'(proto_err), 0);

    // reset in the middle of a write handshake
    sw = 6'd4;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ifc.WRITE) found = 1'b1;
    end
    chk("rst_wr_strobe", 32'(found), 1);
    repeat (2) @(negedge clk);
    chk("rst_oe_before", 32'(ifc.DATA_OE), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_write", 32'(ifc.WRITE), 0);
    chk("rst_mid_oe", 32'(ifc.DATA_OE), 0);
    chk("rst_mid_err", 32'(err), 0);
    chk("rst_mid_col", 32'(ifc.ADDR_COL_IN), 0);
    chk("rst_mid_data", 32'({led, ifc.WDATA}), 0);
    sw = '0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
